// File: rtl/seg_pkg.sv
// ============================================================================
// Package     : seg_pkg
// Description : Shared constants and the active-low hex-to-seven-segment table
//               used by the seg_scan_driver display stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_pkg;

    // Segment pattern with every segment dark (active-low drive).
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Default geometry: two hex digits, four clocks per digit.
    localparam int NDIG_DEFAULT = 2;
    localparam int DIV_DEFAULT  = 4;

    // Active-low hex decode, bit order g..a (bit6 = g, bit0 = a).
    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        seg = SEG_OFF;
        case (hex)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = SEG_OFF;
        endcase
        return seg;
    endfunction

endpackage : seg_pkg

`default_nettype wire

// File: rtl/hex7seg.sv
// ============================================================================
// Module      : hex7seg
// Description : Purely combinational 4-bit hex to 7-bit active-low segment
//               decoder (bit order g..a).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    // Table lookup lives in the package so every user decodes identically.
    always_comb begin
        seg_o = hex_to_seg(hex_i);
    end

endmodule : hex7seg

`default_nettype wire

// File: rtl/seg_scan_driver.sv
// ============================================================================
// Module      : seg_scan_driver
// Description : Double-buffered, time-multiplexed seven-segment hex display
//               driver. A value accepted over valid/ready is held in a shadow
//               register and copied to the displayed register only at a frame
//               boundary, so a frame never mixes old and new digits.
//               Optional macro SEG_SCAN_LZB_EN enables leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NDIG = NDIG_DEFAULT,
    parameter int DIV  = DIV_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [4*NDIG-1:0] in_data,
    output logic              in_ready,
    output logic [6:0]        seg,
    output logic [NDIG-1:0]   an,
    output logic              frame_done
);

    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int DIVW = (DIV  > 1) ? $clog2(DIV)  : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NDIG - 1);
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(DIV - 1);

    logic [DIVW-1:0]   div_q,     div_d;
    logic [IDXW-1:0]   idx_q,     idx_d;
    logic [4*NDIG-1:0] shadow_q,  shadow_d;
    logic [4*NDIG-1:0] active_q,  active_d;
    logic              pending_q, pending_d;
    logic [6:0]        seg_q,     seg_d;
    logic [NDIG-1:0]   an_q,      an_d;
    logic              fdone_q,   fdone_d;

    logic              div_wrap;
    logic              frame_wrap;
    logic              accept;
    logic [4*NDIG-1:0] active_shifted;
    logic [6:0]        digit_seg;
    logic              digit_blank;

    // Digit currently being scanned, selected from the displayed value.
    always_comb begin
        active_shifted = active_q >> {idx_q, 2'b00};
    end

    hex7seg u_hex7seg (
        .hex_i (active_shifted[3:0]),
        .seg_o (digit_seg)
    );

    // Blank a digit when it and every digit above it are zero (digit 0 never blanks).
`ifdef SEG_SCAN_LZB_EN
    always_comb begin
        digit_blank = (idx_q != '0) && (active_shifted == '0);
    end
`else
    always_comb begin
        digit_blank = 1'b0;
    end
`endif

    // Scan timing, handshake, double-buffer commit and registered output values.
    always_comb begin
        div_wrap   = (div_q == DIV_LAST);
        frame_wrap = div_wrap && (idx_q == IDX_LAST);
        accept     = in_valid && !pending_q;

        div_d = div_wrap ? '0 : div_q + 1'b1;
        idx_d = idx_q;
        if (div_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        // Commit looks at the pre-edge pending flag, so a value accepted on
        // the wrap cycle waits for the next frame boundary.
        shadow_d  = accept ? in_data : shadow_q;
        active_d  = (frame_wrap && pending_q) ? shadow_q : active_q;
        pending_d = pending_q;
        if (frame_wrap) begin
            pending_d = 1'b0;
        end
        if (accept) begin
            pending_d = 1'b1;
        end

        an_d    = ~(NDIG'(1) << idx_q);
        seg_d   = digit_blank ? SEG_OFF : digit_seg;
        fdone_d = frame_wrap;
    end

    // State and output registers; reset blanks the display and drops pending data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q     <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            seg_q     <= SEG_OFF;
            an_q      <= '1;
            fdone_q   <= 1'b0;
        end else begin
            div_q     <= div_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
            fdone_q   <= fdone_d;
        end
    end

    assign in_ready   = ~pending_q;
    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = fdone_q;

endmodule : seg_scan_driver

`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
// ============================================================================
// Module      : tb_seg_scan_driver
// Description : Directed self-checking bench for seg_scan_driver (NDIG=2,
//               DIV=4). Honours SEG_SCAN_LZB_EN for the leading-zero case.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_driver;

    localparam int NDIG = 2;
    localparam int DIV  = 4;

    localparam logic [6:0] S_OFF = 7'h7F;
    localparam logic [6:0] S_0   = 7'b1000000;
    localparam logic [6:0] S_1   = 7'b1111001;
    localparam logic [6:0] S_2   = 7'b0100100;
    localparam logic [6:0] S_3   = 7'b0110000;
    localparam logic [6:0] S_5   = 7'b0010010;
    localparam logic [6:0] S_A   = 7'b0001000;
    localparam logic [6:0] S_C   = 7'b1000110;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic [4*NDIG-1:0] in_data;
    logic              in_ready;
    logic [6:0]        seg;
    logic [NDIG-1:0]   an;
    logic              frame_done;

    int n_vec;
    int n_bad;

    seg_scan_driver #(.NDIG(NDIG), .DIV(DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to the negedge where frame_done is high (bounded).
    task automatic wait_fd(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 40);
        check_val({tag, "_fd_seen"}, 32'(frame_done), 32'd1);
    endtask

    // Called on the frame_done negedge: checks the whole next frame.
    task automatic show_frame(input string tag, input logic [6:0] exp0, input logic [6:0] exp1);
        @(negedge clk);
        check_val({tag, "_an0"},  32'(an),  32'h2);
        check_val({tag, "_seg0"}, 32'(seg), 32'(exp0));
        repeat (DIV) @(negedge clk);
        check_val({tag, "_an1"},  32'(an),  32'h1);
        check_val({tag, "_seg1"}, 32'(seg), 32'(exp1));
    endtask

    // One-cycle valid pulse from a negedge; in_ready must drop afterwards.
    task automatic load(input string tag, input logic [7:0] val);
        in_valid = 1'b1;
        in_data  = val;
        @(negedge clk);
        in_valid = 1'b0;
        check_val({tag, "_rdy_low"}, 32'(in_ready), 32'd0);
    endtask

    initial begin
        n_vec    = 0;
        n_bad    = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;

        // Reset state
        #12;
        check_val("rst_seg", 32'(seg),        32'(S_OFF));
        check_val("rst_an",  32'(an),         32'h3);
        check_val("rst_rdy", 32'(in_ready),   32'd1);
        check_val("rst_fd",  32'(frame_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("post_an0",  32'(an),  32'h2);
        check_val("post_seg0", 32'(seg), 32'(S_0));
        repeat (DIV) @(negedge clk);
        check_val("post_an1",  32'(an),  32'h1);
        check_val("post_seg1", 32'(seg), 32'(S_0));

        // Load A5
        wait_fd("a5_pre");
        load("a5", 8'hA5);
        wait_fd("a5");
        check_val("a5_rdy_back", 32'(in_ready), 32'd1);
        show_frame("a5", S_5, S_A);

        // Backpressure: 11 held while 22 pending
        wait_fd("bp_pre");
        in_valid = 1'b1;
        in_data  = 8'h22;
        @(negedge clk);
        in_data  = 8'h11;
        check_val("bp_rdy0", 32'(in_ready), 32'd0);
        @(negedge clk);
        check_val("bp_rdy1", 32'(in_ready), 32'd0);
        wait_fd("bp22");
        show_frame("bp22", S_2, S_2);
        in_valid = 1'b0;
        wait_fd("bp11");
        show_frame("bp11", S_1, S_1);

        // Accept on the frame-wrap cycle
        wait_fd("wrap_pre");
        repeat (2*DIV - 1) @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h3C;
        @(negedge clk);
        in_valid = 1'b0;
        check_val("wrap_fd",  32'(frame_done), 32'd1);
        check_val("wrap_rdy", 32'(in_ready),   32'd0);
        show_frame("wrap_old", S_1, S_1);
        wait_fd("wrap_new");
        show_frame("wrap_new", S_C, S_3);

        // Reset mid-frame with a pending value
        wait_fd("mrst_pre");
        load("mrst", 8'h77);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("mrst_seg", 32'(seg),        32'(S_OFF));
        check_val("mrst_an",  32'(an),         32'h3);
        check_val("mrst_rdy", 32'(in_ready),   32'd1);
        check_val("mrst_fd",  32'(frame_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("mrst_an0",  32'(an),  32'h2);
        check_val("mrst_seg0", 32'(seg), 32'(S_0));
        repeat (DIV) @(negedge clk);
        check_val("mrst_an1",  32'(an),  32'h1);
        check_val("mrst_seg1", 32'(seg), 32'(S_0));
        wait_fd("mrst_frame");
        show_frame("mrst_frame", S_0, S_0);

        // Load 05: leading-zero behaviour
        wait_fd("lz_pre");
        load("lz", 8'h05);
        wait_fd("lz");
`ifdef SEG_SCAN_LZB_EN
        show_frame("lz", S_5, S_OFF);
`else
        show_frame("lz", S_5, S_0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_seg_scan_driver

`default_nettype wire

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Downstream display stage for the shifter/LFSR value bus.
- Accepts a packed hex value over a valid/ready handshake and double-buffers it.
- Time-multiplexes NDIG seven-segment digits through one shared segment bus plus per-digit enables.
- New values commit only at frame boundaries, so the display never tears.

Parameters:
NDIG, 2, number of hex digits displayed; must be >= 1
DIV, 4, clock cycles each digit stays lit; must be >= 1

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  producer presents in_data
in_data  input  4*NDIG  packed hex digits; digit k = in_data[4k+3:4k]
in_ready  output  1  driver can accept a new value
seg  output  7  segment drive, active-low; bit0=a … bit6=g
an  output  NDIG  digit enables, active-low one-hot
frame_done  output  1  one-cycle pulse when the last digit's slot ends

Behaviour:
- Interface clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values (asynchronous, take effect immediately):
  - shadow = 0, active = 0, pending = 0, digit index = 0, divider = 0.
  - seg = 7'h7F, an = all ones, frame_done = 0.
  - in_ready = 1, since it is combinationally ~pending.
- Divider:
  - Counts 0..DIV-1.
  - At DIV-1 it returns to 0 and the digit index advances.
  - Index wraps from NDIG-1 to 0.
  - DIV=1 advances every cycle.
- Frame wrap is the cycle where the divider is at DIV-1 and the index is at NDIG-1. On that cycle:
  - frame_done is registered high for the following cycle.
  - If pending = 1: active <= shadow and pending <= 0.
- Handshake:
  - Transfer occurs when in_valid & in_ready: shadow <= in_data, pending <= 1.
  - While pending = 1, in_ready = 0. in_data is ignored and shadow is never overwritten.
- Simultaneous accept and frame wrap:
  - Commit uses the pre-edge pending value, which is 0, so nothing commits.
  - The new value becomes pending and commits at the next frame wrap.
- Outputs are registered, so seg/an reflect the index/active state with 1-cycle latency.
  - an[idx] = 0, all other bits = 1.
  - seg = hex decode of active digit idx.
- First post-reset cycle: outputs still show the reset values. The next cycle shows digit 0 of active (0 → 7'b1000000).
- Decode table, written as g..a: 0=1000000, 1=1111001, 5=0010010, 8=0000000, A=0001000, F=0001110. Full 0-F table is in the package.
- Reset asserted mid-frame or mid-handshake:
  - Immediate blank.
  - Pending data is discarded.
  - Scanning restarts at digit 0 after release.

Optional Feature:
- Macro SEG_SCAN_LZB_EN enables leading-zero blanking.
- Defined:
  - Any digit above the most significant non-zero digit of active drives seg = 7'h7F; its an bit still asserts.
  - Digit 0 is always shown, so active = 0 displays "0".
- Undefined: every digit is decoded normally.

Decomposition:
- Package seg_pkg:
  - SEG_OFF = 7'h7F.
  - The 16-entry active-low hex segment table, or a hex_to_seg function.
  - Default NDIG/DIV localparams.
- Sub-module hex7seg: purely combinational 4-bit → 7-bit active-low decoder, instantiated once on the muxed digit.

Test Plan:
All scenarios use NDIG=2, DIV=4.
- Reset held: seg=7F, an=11, in_ready=1, frame_done=0; after release, an alternates 10/01 every 4 cycles and seg=1000000.
- Load 8'hA5:
  - in_ready drops the cycle after transfer.
  - After the next frame_done: an=10 with seg=0010010, and an=01 with seg=0001000.
  - in_ready returns to 1.
- Backpressure:
  - Present 8'h11 while 8'h22 is pending; in_ready=0 and shadow stays 22.
  - 22 displays after frame_done; 11 is then accepted and displays one frame later.
- Accept on the frame-wrap cycle: 8'h3C is not shown at that wrap; it is shown after the following frame_done.
- Assert rst mid-frame with a pending value: same cycle seg=7F, an=11; after release, 00 displays and in_ready=1.
- Load 8'h05:
  - With SEG_SCAN_LZB_EN: digit 1 seg=7F, digit 0 seg=0010010.
  - Without it: digit 1 seg=1000000.
